// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter and its round-robin picker.
// The ROB geometry defines live here so that every file compiled after this one agrees on tag width.
`ifndef CDB_PARAMS_DEFINED
`define CDB_PARAMS_DEFINED
`define ROB_SIZE    32
`define ROB_WIDTH   5
`define CDB_SRC_NUM 3
`endif

package cdb_arbiter_pkg;

   localparam int ROB_W       = `ROB_WIDTH;
   localparam int CDB_SRC_NUM = `CDB_SRC_NUM;
   localparam int VALUE_W     = 32;

   typedef enum logic [1:0] {
      SRC_ALU    = 2'd0,
      SRC_LSB    = 2'd1,
      SRC_BRANCH = 2'd2
   } cdb_src_e;

endpackage

// File: rtl/cdb_rr_pick.sv
// Purely combinational round-robin picker: scans requests starting one past the last grant.
// Kept generic so the RS issue selector can reuse it.
module cdb_rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   gidx,
   output logic               any
);

   logic [IDX_W-1:0] idx;

   // First requester found after 'last' (wrapping) wins; later hits are masked by 'any'.
   always_comb begin
      grant = '0;
      gidx  = '0;
      any   = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((int'(last) + k) % NUM_REQ);
         if (!any && req[idx]) begin
            grant[idx] = 1'b1;
            gidx       = idx;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Drains one-entry per-source holding buffers onto the registered common data bus,
// one broadcast per cycle in round-robin order. Flush empties every buffer.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = CDB_SRC_NUM,
   parameter int IDX_W   = $clog2(NUM_SRC)
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       rdy_in,
   input  logic                       clear,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [NUM_SRC*ROB_W-1:0]   src_rob_id,
   input  logic [NUM_SRC*VALUE_W-1:0] src_value,
   output logic [NUM_SRC-1:0]         src_ready,
   output logic                       cdb_valid,
   output logic [ROB_W-1:0]           cdb_rob_id,
   output logic [VALUE_W-1:0]         cdb_value
);

   logic [NUM_SRC-1:0] buf_valid;
   logic [ROB_W-1:0]   buf_rob_id [NUM_SRC];
   logic [VALUE_W-1:0] buf_value  [NUM_SRC];
   logic [IDX_W-1:0]   last;

   logic [NUM_SRC-1:0] grant;
   logic [IDX_W-1:0]   gidx;
   logic               any;
   logic [NUM_SRC-1:0] accept;

   cdb_rr_pick #(
      .NUM_REQ (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (buf_valid),
      .last  (last),
      .grant (grant),
      .gidx  (gidx),
      .any   (any)
   );

   // A buffer draining this cycle can take a new entry at the same edge, keeping a sole requester at full rate.
   assign src_ready = {NUM_SRC{rdy_in & ~clear}} & (~buf_valid | grant);
   assign accept    = src_valid & src_ready;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         buf_valid  <= '0;
         last       <= IDX_W'(NUM_SRC - 1);
         cdb_valid  <= 1'b0;
         cdb_rob_id <= '0;
         cdb_value  <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            buf_rob_id[i] <= '0;
            buf_value[i]  <= '0;
         end
      end else if (rdy_in) begin
         if (clear) begin
            buf_valid <= '0;
            cdb_valid <= 1'b0;
            last      <= IDX_W'(NUM_SRC - 1);
         end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
               if (accept[i]) begin
                  buf_valid[i]  <= 1'b1;
                  buf_rob_id[i] <= src_rob_id[i*ROB_W +: ROB_W];
                  buf_value[i]  <= src_value[i*VALUE_W +: VALUE_W];
               end else if (grant[i]) begin
                  buf_valid[i]  <= 1'b0;
               end
            end
            cdb_valid <= |buf_valid;
            if (any) begin
               cdb_rob_id <= buf_rob_id[gidx];
               cdb_value  <= buf_value[gidx];
               last       <= gidx;
            end
         end
      end
   end

endmodule
